jump_table_loader: RTL and testbench
====================================

Name: jump_table_loader

Overview:
- Writer side of the jump-target lookup table: fills the table that the fetch stage's next-PC lookup reads.
- Accepts a byte stream over a valid/ready handshake and assembles 3-byte records. Each record is one jump instruction address plus its signed PC offset.
- Issues one single-cycle write per record into the table's write port, with a sequential entry index.
- Tracks entry count, terminates on a sentinel record, and flags overflow.

Parameters:
- D, 12, PC / offset width in bits. Packing below is defined for D=12 only.
- DEPTH, 256, table entries. wr_idx width is $clog2(DEPTH); count width is $clog2(DEPTH)+1.

Ports:
- clk  input  1  system clock, all state on posedge
- reset_n  input  1  asynchronous active-low reset
- start  input  1  one-cycle pulse: clear table fill state and begin a new load
- in_data  input  8  stream byte
- in_valid  input  1  in_data valid
- in_ready  output  1  loader accepts byte this cycle; transfer = in_valid & in_ready
- wr_en  output  1  one-cycle table write strobe
- wr_idx  output  8  table entry index for this write
- wr_addr  output  D  jump instruction address to store
- wr_off  output  D  two's-complement offset to store
- count  output  9  entries written since last start (0..256)
- done  output  1  sentinel received; load complete (sticky)
- overflow  output  1  a record arrived with the table full (sticky)

Behaviour:
- Reset (async, reset_n=0) sets: state=IDLE, in_ready=0, wr_en=0, wr_idx=0, wr_addr=0, wr_off=0, count=0, done=0, overflow=0.
- Reset mid-load discards any partial record. No write is issued.
- Record packing, 3 transferred bytes in order:
  - B0 = addr[7:0]
  - B1 = {off[3:0], addr[11:8]}
  - B2 = off[11:4]
- States: IDLE, BYTE0, BYTE1, BYTE2, DONE.
  - IDLE: in_ready=0. start -> BYTE0.
  - BYTE0 / BYTE1: in_ready=1. A transfer latches the byte and advances to the next state. No transfer: hold.
  - BYTE2: in_ready=1. A transfer completes the record and leads to one of three outcomes below.
  - DONE: in_ready=0, done=1. Only start or reset leaves it.
- Record completion in BYTE2:
  - Sentinel (addr==12'hFFF and off==0): no write; go to DONE; done=1 from the next cycle.
  - Otherwise, if count<DEPTH: next cycle wr_en=1 for exactly one cycle, with wr_idx=count[7:0] and wr_addr/wr_off = the assembled record. count increments in that same cycle. State returns to BYTE0.
  - Otherwise, if count==DEPTH: no write; overflow set (sticky); state returns to BYTE0. Bytes keep being accepted and dropped until the sentinel arrives.
- Latency: last byte accepted at cycle N -> wr_en high at N+1.
- Back-to-back records at one byte per cycle are sustained with no bubbles; in_ready stays 1 through the write cycle.
- wr_addr, wr_off and wr_idx hold their last values when wr_en=0.
- start, from any state including mid-record and DONE:
  - next cycle: state=BYTE0, count=0, done=0, overflow=0; partial record discarded.
  - A transfer in the same cycle as start is ignored; the source must resend that byte.
  - A wr_en pulse already scheduled for that cycle still occurs.
- wr_idx wraps naturally: the 256th entry uses idx 255, and count reaches 256.
- Offsets are stored as given; sign interpretation belongs to the reader. 12'hFFF with off==0 is the only reserved address.

Test Plan:
- Reset, start, then bytes 0x04,0xF0,0xFF (addr=0x004, off=0xFFF = -1) -> one cycle later: wr_en=1, wr_idx=0, wr_addr=0x004, wr_off=0xFFF; count=1.
- Two records at one byte per cycle: {0x14,0x40,0x01} (addr=0x014, off=0x014), then {0x30,0xB0,0xFF} (addr=0x030, off=0xFFB = -5) -> wr_en pulses exactly 3 cycles apart, idx 0 then 1; count=2; in_ready never drops.
- After 2 entries, send sentinel 0xFF,0x0F,0x00 -> no wr_en; done=1 next cycle; in_ready=0; count stays 2; further in_valid bytes are not accepted.
- Load 256 non-sentinel records, then a 257th -> 256 writes with idx 0..255; count=256; overflow=1 after the 257th; no 257th wr_en; sentinel then sets done.
- Start, then send 0x04,0x00; pulse start in the same cycle as a third byte -> no write; count=0; the byte is dropped; next 3 bytes form a fresh record written at idx 0.
- Assert reset_n=0 asynchronously mid-BYTE1 between clock edges -> all outputs return to reset values immediately; in_ready=0 until the next start.

Source files
------------

// File: rtl/jump_table_loader.sv
// Writer side of the jump-target table: assembles 3-byte {addr, offset} records
// from a byte stream and issues one indexed table write per record.
module jump_table_loader #(
  parameter int D     = 12,
  parameter int DEPTH = 256,
  localparam int IW   = $clog2(DEPTH),
  localparam int CW   = IW + 1
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          start,
  input  logic [7:0]    in_data,
  input  logic          in_valid,
  output logic          in_ready,
  output logic          wr_en,
  output logic [IW-1:0] wr_idx,
  output logic [D-1:0]  wr_addr,
  output logic [D-1:0]  wr_off,
  output logic [CW-1:0] count,
  output logic          done,
  output logic          overflow
);

  typedef enum logic [2:0] {IDLE, BYTE0, BYTE1, BYTE2, DONE} state_t;

  state_t        state, state_nxt;
  logic [7:0]    b0, b1;
  logic          xfer, sentinel, room;
  logic [D-1:0]  rec_addr, rec_off;

  assign in_ready = (state == BYTE0) || (state == BYTE1) || (state == BYTE2);
  assign done     = (state == DONE);
  // A byte offered alongside start is dropped; the source resends it.
  assign xfer     = in_valid & in_ready & ~start;

  // Record as it stands once the third byte (in_data) lands.
  assign rec_addr = {b1[3:0], b0};
  assign rec_off  = {in_data, b1[7:4]};
  assign sentinel = (rec_addr == {D{1'b1}}) && (rec_off == '0);
  assign room     = (count < CW'(DEPTH));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = IDLE;
      BYTE0:   if (xfer) state_nxt = BYTE1;
      BYTE1:   if (xfer) state_nxt = BYTE2;
      BYTE2:   if (xfer) state_nxt = sentinel ? DONE : BYTE0;
      DONE:    state_nxt = DONE;
      default: state_nxt = IDLE;
    endcase
    if (start) state_nxt = BYTE0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      b0       <= '0;
      b1       <= '0;
      wr_en    <= 1'b0;
      wr_idx   <= '0;
      wr_addr  <= '0;
      wr_off   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      wr_en <= 1'b0;
      if (start) begin
        count    <= '0;
        overflow <= 1'b0;
      end else if (xfer) begin
        case (state)
          BYTE0: b0 <= in_data;
          BYTE1: b1 <= in_data;
          BYTE2: begin
            // Full table: record is dropped, loading continues until sentinel.
            if (!sentinel) begin
              if (room) begin
                wr_en   <= 1'b1;
                wr_idx  <= count[IW-1:0];
                wr_addr <= rec_addr;
                wr_off  <= rec_off;
                count   <= count + 1'b1;
              end else begin
                overflow <= 1'b1;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_jump_table_loader.sv
// Randomized bench for jump_table_loader against a byte-list reference model.
module tb_jump_table_loader;
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  in_data = '0;
  logic        in_valid = 1'b0;
  logic        in_ready, wr_en, done, overflow;
  logic [7:0]  wr_idx;
  logic [11:0] wr_addr, wr_off;
  logic [8:0]  count;

  jump_table_loader #(.D(12), .DEPTH(256)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .in_data(in_data),
    .in_valid(in_valid), .in_ready(in_ready), .wr_en(wr_en), .wr_idx(wr_idx),
    .wr_addr(wr_addr), .wr_off(wr_off), .count(count), .done(done),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  int n_vec = 0, n_err = 0;

  // Reference model: a loading flag, the bytes gathered so far, and the last write.
  bit          m_loading, m_done, m_ovf, m_wr;
  int          m_cnt;
  logic [7:0]  m_bytes[$];
  logic [7:0]  m_idx;
  logic [11:0] m_addr, m_off;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_loading = 0; m_done = 0; m_ovf = 0; m_wr = 0; m_cnt = 0;
    m_bytes.delete();
    m_idx = '0; m_addr = '0; m_off = '0;
  endtask

  task automatic model_step(input bit st, input bit v, input logic [7:0] d);
    logic [11:0] a, o;
    m_wr = 0;
    if (st) begin
      m_loading = 1; m_done = 0; m_cnt = 0; m_ovf = 0;
      m_bytes.delete();
    end else if (v && m_loading) begin
      m_bytes.push_back(d);
      if (m_bytes.size() == 3) begin
        a = 12'(m_bytes[0]) + 12'(m_bytes[1] % 16) * 256;
        o = 12'(m_bytes[1] / 16) + 12'(m_bytes[2]) * 16;
        m_bytes.delete();
        if (a == 12'hFFF && o == 12'h000) begin
          m_done = 1; m_loading = 0;
        end else if (m_cnt < 256) begin
          m_wr = 1; m_idx = 8'(m_cnt); m_addr = a; m_off = o; m_cnt++;
        end else begin
          m_ovf = 1;
        end
      end
    end
  endtask

  task automatic check_outs(input string pfx);
    chk({pfx, "wr_en"},    wr_en,    m_wr);
    chk({pfx, "wr_idx"},   wr_idx,   m_idx);
    chk({pfx, "wr_addr"},  wr_addr,  m_addr);
    chk({pfx, "wr_off"},   wr_off,   m_off);
    chk({pfx, "count"},    count,    m_cnt);
    chk({pfx, "done"},     done,     m_done);
    chk({pfx, "overflow"}, overflow, m_ovf);
  endtask

  // One clock: drive after negedge, check ready, step model at posedge, check at negedge.
  task automatic cyc(input bit st, input bit v, input logic [7:0] d);
    start = st; in_valid = v; in_data = d;
    #1 chk("in_ready", in_ready, m_loading);
    @(posedge clk);
    model_step(st, v, d);
    @(negedge clk);
    check_outs("");
    start = 0; in_valid = 0;
  endtask

  task automatic send_byte(input logic [7:0] d, input bit dense);
    bit v, r;
    for (int t = 0; t < 16; t++) begin
      v = dense ? 1'b1 : ($urandom_range(0, 3) != 0);
      r = m_loading;
      cyc(0, v, d);
      if (!r || v) return;
    end
  endtask

  task automatic send_rec(input logic [11:0] a, input logic [11:0] o, input bit dense);
    logic [7:0] b1;
    b1 = {o[3:0], a[11:8]};
    send_byte(a[7:0], dense);
    send_byte(b1, dense);
    send_byte(o[11:4], dense);
  endtask

  initial begin
    logic [11:0] ra, ro;
    int r;
    model_reset();
    repeat (3) @(negedge clk);
    check_outs("rst_");
    chk("rst_in_ready", in_ready, 0);
    reset_n = 1;
    @(negedge clk);

    // Single record with negative offset
    cyc(1, 0, 0);
    send_rec(12'h004, 12'hFFF, 1);
    chk("t1_wr_en", wr_en, 1);
    chk("t1_addr", wr_addr, 12'h004);
    chk("t1_off", wr_off, 12'hFFF);
    chk("t1_count", count, 1);

    // Back-to-back records, then sentinel
    cyc(1, 0, 0);
    send_rec(12'h014, 12'h014, 1);
    send_rec(12'h030, 12'hFFB, 1);
    chk("t2_idx", wr_idx, 1);
    chk("t2_count", count, 2);
    send_rec(12'hFFF, 12'h000, 1);
    chk("t2_done", done, 1);
    cyc(0, 1, 8'h55);
    cyc(0, 1, 8'h66);
    chk("t2_count_hold", count, 2);

    // Fill to capacity, overflow, sentinel
    cyc(1, 0, 0);
    for (int i = 0; i < 256; i++) begin
      ro = 12'($urandom);
      send_rec(12'(i), ro, i[0]);
    end
    chk("t3_count", count, 256);
    chk("t3_idx", wr_idx, 255);
    send_rec(12'h123, 12'h456, 1);
    chk("t3_ovf", overflow, 1);
    chk("t3_count_sat", count, 256);
    send_rec(12'hFFF, 12'h000, 1);
    chk("t3_done", done, 1);

    // start coincident with the third byte drops the partial record
    cyc(1, 0, 0);
    send_byte(8'h04, 1);
    send_byte(8'h00, 1);
    cyc(1, 1, 8'hAA);
    chk("t4_count", count, 0);
    chk("t4_ovf", overflow, 0);
    send_rec(12'h077, 12'h003, 1);
    chk("t4_idx", wr_idx, 0);
    chk("t4_addr", wr_addr, 12'h077);

    // Randomized mix of records, sentinels, stray starts and idle bytes
    cyc(1, 0, 0);
    for (int k = 0; k < 400; k++) begin
      r = $urandom_range(0, 99);
      if (!m_loading && r < 50) cyc(1, 0, 0);
      else if (r < 4) send_rec(12'hFFF, 12'h000, $urandom_range(0, 1));
      else if (r < 8) cyc(1, $urandom_range(0, 1), 8'($urandom));
      else if (r < 12) send_byte(8'($urandom), $urandom_range(0, 1));
      else if (r < 16) send_rec(12'hFFF, 12'($urandom_range(1, 4095)), 1);
      else begin
        ra = 12'($urandom); ro = 12'($urandom);
        send_rec(ra, ro, $urandom_range(0, 1));
      end
    end

    // Asynchronous reset while a record is half assembled
    cyc(1, 0, 0);
    send_byte(8'h12, 1);
    #2 reset_n = 0;
    #1 model_reset();
    check_outs("arst_");
    chk("arst_in_ready", in_ready, 0);
    @(negedge clk);
    reset_n = 1;
    cyc(0, 1, 8'h33);
    cyc(1, 0, 0);
    send_rec(12'h0AB, 12'h801, 1);
    chk("arst_idx", wr_idx, 0);
    chk("arst_addr", wr_addr, 12'h0AB);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
